sys_trap_ctrl: RTL and testbench

- Trap/interrupt controller sitting directly upstream of the system privilege register.
- Latches external interrupt edges and software syscall requests, and arbitrates them at instruction boundaries.
- On trap entry it pulses to_sys, which drops the privilege register to system level (0), and records the cause and the pre-trap privilege.
- On return-from-interrupt it restores the saved level through privilage_we/privilage_level.

---
 rtl/sys_trap_if.sv | 35 +++
 rtl/sys_trap_ctrl.sv | 132 +++++++++++++
 tb/tb_sys_trap_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sys_trap_if.sv
// sys_trap_if: CPU-side bus of the trap controller.
//   master : CPU / stimulus side (drives irq, mask write, syscall, boundary, privilege, rti)
//   slave  : sys_trap_ctrl side (drives strobes, cause, pending, mask, status)
interface sys_trap_if #(
  parameter int NUM_IRQ = 8,
  parameter int CAUSE_W = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic               irq_mask_we;
  logic [NUM_IRQ-1:0] irq_mask_in;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               syscall;
  logic               instr_boundary;
  logic               privilage;
  logic               rti;
  logic               to_sys;
  logic               privilage_we;
  logic               privilage_level;
  logic [CAUSE_W-1:0] trap_cause;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               in_trap;
  logic               trap_fault;

  modport master (
    output irq, irq_mask_we, irq_mask_in, syscall, instr_boundary, privilage, rti,
    input  irq_mask, to_sys, privilage_we, privilage_level, trap_cause,
           irq_pending, in_trap, trap_fault
  );

  modport slave (
    input  irq, irq_mask_we, irq_mask_in, syscall, instr_boundary, privilage, rti,
    output irq_mask, to_sys, privilage_we, privilage_level, trap_cause,
           irq_pending, in_trap, trap_fault
  );
endinterface

// File: rtl/sys_trap_ctrl.sv
// sys_trap_ctrl: trap/interrupt controller feeding the privilege register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sys_trap_if.slave
//     irq/irq_mask_we/irq_mask_in -> edge-latched interrupts, mask register
//     syscall/instr_boundary      -> software trap, taken only at a boundary
//     privilage/rti               -> current level, return-from-interrupt pulse
//     to_sys                      -> 1-cycle trap-entry pulse (drop to level 0)
//     privilage_we/_level         -> 1-cycle restore of the saved level
//     trap_cause                  -> 0 = syscall, i+1 = irq[i]
//     irq_pending/in_trap/trap_fault -> status

// Per-line edge detector and pending latch.
module sys_trap_irq_cell (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic take,
  output logic pending
);
  logic irq_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_prev <= irq;
      // A fresh edge in the take cycle must not be lost: set beats clear.
      if (irq && !irq_prev) pending <= 1'b1;
      else if (take)        pending <= 1'b0;
    end
  end
endmodule

module sys_trap_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int CAUSE_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  sys_trap_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, ENTER, IN_TRAP, RETURN} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] lowest;
  logic [NUM_IRQ-1:0] take_vec;
  logic [CAUSE_W-1:0] irq_cause;
  logic               take;
  logic               saved_priv;
  logic               to_sys_q;
  logic               pwe_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               fault_q;

  // Arbitration uses the mask register as it stood before any same-cycle write.
  assign elig   = pending & mask;
  assign lowest = elig & (~elig + NUM_IRQ'(1));
  assign take   = (state == IDLE) && bus.instr_boundary && (bus.syscall || (|elig));
  // syscall outranks interrupts, so no pending bit is consumed then.
  assign take_vec = (take && !bus.syscall) ? lowest : '0;

  always_comb begin
    irq_cause = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (elig[i]) irq_cause = CAUSE_W'(i + 1);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_irq
      sys_trap_irq_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .irq     (bus.irq[g]),
        .take    (take_vec[g]),
        .pending (pending[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      saved_priv <= 1'b0;
      to_sys_q   <= 1'b0;
      pwe_q      <= 1'b0;
      cause_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      to_sys_q <= 1'b0;
      pwe_q    <= 1'b0;
      if (bus.irq_mask_we) mask <= bus.irq_mask_in;
      // rti is only meaningful while parked in IN_TRAP.
      if (bus.rti && state != IN_TRAP) fault_q <= 1'b1;
      case (state)
        IDLE: begin
          if (take) begin
            state      <= ENTER;
            to_sys_q   <= 1'b1;
            saved_priv <= bus.privilage;
            cause_q    <= bus.syscall ? '0 : irq_cause;
          end
        end
        ENTER: state <= IN_TRAP;
        IN_TRAP: begin
          // No nesting: a syscall inside a trap handler is a protocol error.
          if (bus.syscall && bus.instr_boundary) fault_q <= 1'b1;
          if (bus.rti) begin
            state <= RETURN;
            pwe_q <= 1'b1;
          end
        end
        RETURN:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.irq_mask        = mask;
  assign bus.irq_pending     = pending;
  assign bus.to_sys          = to_sys_q;
  assign bus.privilage_we    = pwe_q;
  assign bus.privilage_level = saved_priv;
  assign bus.trap_cause      = cause_q;
  assign bus.in_trap         = (state != IDLE);
  assign bus.trap_fault      = fault_q;
endmodule

// File: tb/tb_sys_trap_ctrl.sv
module tb_sys_trap_ctrl;
  localparam int NUM_IRQ = 8;
  localparam int CAUSE_W = 4;

  typedef struct packed {
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] min;
    logic       sc;
    logic       ib;
    logic       pv;
    logic       rti;
  } in_t;

  typedef struct packed {
    logic       ts;
    logic       pwe;
    logic       pl;
    logic [3:0] cause;
    logic [7:0] pend;
    logic       it;
    logic       flt;
    logic [7:0] mask;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t v [$];

  sys_trap_if #(.NUM_IRQ(NUM_IRQ), .CAUSE_W(CAUSE_W)) bus ();

  sys_trap_ctrl #(.NUM_IRQ(NUM_IRQ), .CAUSE_W(CAUSE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [7:0] irq, input logic mwe, input logic [7:0] min,
    input logic sc, input logic ib, input logic pv, input logic rti,
    input logic ts, input logic pwe, input logic pl, input logic [3:0] cause,
    input logic [7:0] pend, input logic it, input logic flt, input logic [7:0] mask);
    vec_t r;
    r.i = '{irq, mwe, min, sc, ib, pv, rti};
    r.o = '{ts, pwe, pl, cause, pend, it, flt, mask};
    return r;
  endfunction

  function automatic out_t sample();
    out_t a;
    a = '{bus.to_sys, bus.privilage_we, bus.privilage_level, bus.trap_cause,
          bus.irq_pending, bus.in_trap, bus.trap_fault, bus.irq_mask};
    return a;
  endfunction

  task automatic drive(input in_t x);
    bus.irq            = x.irq;
    bus.irq_mask_we    = x.mwe;
    bus.irq_mask_in    = x.min;
    bus.syscall        = x.sc;
    bus.instr_boundary = x.ib;
    bus.privilage      = x.pv;
    bus.rti            = x.rti;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got ts=%b pwe=%b pl=%b cause=%0d pend=%h it=%b flt=%b mask=%h, want ts=%b pwe=%b pl=%b cause=%0d pend=%h it=%b flt=%b mask=%h",
                  name, act.ts, act.pwe, act.pl, act.cause, act.pend, act.it, act.flt, act.mask,
                  exp.ts, exp.pwe, exp.pl, exp.cause, exp.pend, exp.it, exp.flt, exp.mask);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      drive(v[k].i);
      @(posedge clk);
      #1;
      check($sformatf("row%0d", k + 1), v[k].o);
    end
  endtask

  initial begin
    // irq, mwe, min, sc, ib, pv, rti | ts, pwe, pl, cause, pend, it, flt, mask
    // irq[0] high through reset, unmasked one cycle later
    v.push_back(mk(8'h01,0,8'h00,0,0,1,0, 0,0,0,0,8'h01,0,0,8'h00));
    v.push_back(mk(8'h01,1,8'h01,0,1,1,0, 0,0,0,0,8'h01,0,0,8'h01));
    v.push_back(mk(8'h01,0,8'h00,0,1,1,0, 1,0,1,1,8'h00,1,0,8'h01));
    v.push_back(mk(8'h01,0,8'h00,0,0,1,0, 0,0,1,1,8'h00,1,0,8'h01));
    v.push_back(mk(8'h01,0,8'h00,0,0,1,1, 0,1,1,1,8'h00,1,0,8'h01));
    v.push_back(mk(8'h00,0,8'h00,0,0,1,0, 0,0,1,1,8'h00,0,0,8'h01));
    // irq[5]+irq[2] together, priority and return
    v.push_back(mk(8'h00,1,8'hFF,0,0,1,0, 0,0,1,1,8'h00,0,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,1,1,0, 0,0,1,1,8'h24,0,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,1,1,0, 1,0,1,3,8'h20,1,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,0,1,0, 0,0,1,3,8'h20,1,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,0,1,1, 0,1,1,3,8'h20,1,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,1,1,0, 0,0,1,3,8'h20,0,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,1,0,0, 1,0,0,6,8'h00,1,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,0,0,0, 0,0,0,6,8'h00,1,0,8'hFF));
    v.push_back(mk(8'h24,0,8'h00,0,0,0,1, 0,1,0,6,8'h00,1,0,8'hFF));
    v.push_back(mk(8'h00,0,8'h00,0,0,0,0, 0,0,0,6,8'h00,0,0,8'hFF));
    // syscall beats eligible irq[0]
    v.push_back(mk(8'h01,0,8'h00,0,0,0,0, 0,0,0,6,8'h01,0,0,8'hFF));
    v.push_back(mk(8'h01,0,8'h00,1,1,1,0, 1,0,1,0,8'h01,1,0,8'hFF));
    v.push_back(mk(8'h01,0,8'h00,0,0,1,0, 0,0,1,0,8'h01,1,0,8'hFF));
    // in-trap edge, nested syscall fault, rti in IDLE
    v.push_back(mk(8'h03,0,8'h00,0,0,1,0, 0,0,1,0,8'h03,1,0,8'hFF));
    v.push_back(mk(8'h03,0,8'h00,1,1,1,0, 0,0,1,0,8'h03,1,1,8'hFF));
    v.push_back(mk(8'h03,0,8'h00,0,0,1,1, 0,1,1,0,8'h03,1,1,8'hFF));
    v.push_back(mk(8'h03,0,8'h00,0,0,1,0, 0,0,1,0,8'h03,0,1,8'hFF));
    v.push_back(mk(8'h03,0,8'h00,0,0,1,1, 0,0,1,0,8'h03,0,1,8'hFF));
    // irq[4] edge in its own take cycle
    v.push_back(mk(8'h03,1,8'h10,0,0,1,0, 0,0,1,0,8'h03,0,1,8'h10));
    v.push_back(mk(8'h13,0,8'h00,0,0,1,0, 0,0,1,0,8'h13,0,1,8'h10));
    v.push_back(mk(8'h03,0,8'h00,0,0,1,0, 0,0,1,0,8'h13,0,1,8'h10));
    v.push_back(mk(8'h13,0,8'h00,0,1,0,0, 1,0,0,5,8'h13,1,1,8'h10));
    v.push_back(mk(8'h13,0,8'h00,0,0,0,0, 0,0,0,5,8'h13,1,1,8'h10));
    v.push_back(mk(8'h13,0,8'h00,0,0,0,1, 0,1,0,5,8'h13,1,1,8'h10));
    v.push_back(mk(8'h13,0,8'h00,0,1,0,0, 0,0,0,5,8'h13,0,1,8'h10));
    v.push_back(mk(8'h13,0,8'h00,0,1,1,0, 1,0,1,5,8'h03,1,1,8'h10));
    v.push_back(mk(8'h13,0,8'h00,0,0,1,0, 0,0,1,5,8'h03,1,1,8'h10));
    // after mid-trap reset: plain syscall trap
    v.push_back(mk(8'h00,0,8'h00,1,1,1,0, 1,0,1,0,8'h00,1,0,8'h00));
    v.push_back(mk(8'h00,0,8'h00,0,0,1,0, 0,0,1,0,8'h00,1,0,8'h00));
    v.push_back(mk(8'h00,0,8'h00,0,0,1,1, 0,1,1,0,8'h00,1,0,8'h00));
    v.push_back(mk(8'h00,0,8'h00,0,0,1,0, 0,0,1,0,8'h00,0,0,8'h00));

    drive('{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    #2;
    check("reset_state", '{1'b0,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,8'h00});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive('{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    run_rows(0, 32);

    // Asynchronous reset while IN_TRAP with fault set and pending bits live.
    @(negedge clk);
    drive('{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_mid_trap", '{1'b0,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,8'h00});
    @(posedge clk);
    #1;
    check("held_reset_no_pwe", '{1'b0,1'b0,1'b0,4'd0,8'h00,1'b0,1'b0,8'h00});
    @(negedge clk);
    rst = 1'b0;
    run_rows(33, 36);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
